// File: rtl/mask_load_controller_if.sv
// ioctl download bus plus mask-ROM / reader port bundle for mask_load_controller.
// master = ioctl host and mask reader side; slave = controller side.
interface mask_load_controller_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  ioctl_download;
  logic [7:0]            ioctl_index;
  logic                  ioctl_wr;
  logic [15:0]           ioctl_dout;
  logic                  ioctl_wait;
  logic [ADDR_WIDTH-1:0] render_addr;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_wren;
  logic [39:0]           rom_data;
  logic                  render_hold;
  logic                  mask_ready;
  logic [ADDR_WIDTH-1:0] record_count;
  logic [1:0]            load_error;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, render_addr,
    input  ioctl_wait, rom_addr, rom_wren, rom_data, render_hold, mask_ready,
           record_count, load_error
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, render_addr,
    output ioctl_wait, rom_addr, rom_wren, rom_data, render_hold, mask_ready,
           record_count, load_error
  );
endinterface

// File: rtl/mask_load_controller.sv
// Unpacks the 16-bit ioctl stream into 40-bit mask records, writes them to the
// mask ROM and shares the ROM address port with the video-time mask reader.
module mask_load_controller #(
  parameter logic [7:0] MASK_INDEX  = 8'd2,
  parameter int         MAX_RECORDS = 18720,
  parameter int         ADDR_WIDTH  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  mask_load_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOADING, FLUSH, READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MAX_RECORDS);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_dl_d;
  logic [15:0]           r_hold;
  logic [1:0]            r_hold_cnt;
  logic [2:0]            r_rec_cnt;
  logic                  r_rom_wren;
  logic                  r_inc_pend;
  logic [39:0]           r_rom_data;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [1:0]            r_load_error;
  logic                  r_mask_ready;

  logic w_start;
  logic w_fall;
  logic w_shift;
  logic w_accept;
  logic w_flush_done;

  assign w_start      = bus.ioctl_download & ~r_dl_d & (bus.ioctl_index == MASK_INDEX);
  assign w_fall       = ~bus.ioctl_download & r_dl_d;
  assign w_shift      = (r_hold_cnt != 2'd0);
  assign w_accept     = (r_state == LOADING) & bus.ioctl_wr & ~w_shift;
  // FLUSH may only conclude once the last record's write and address bump retired.
  assign w_flush_done = (r_state == FLUSH) & ~w_shift & ~r_rom_wren & ~r_inc_pend;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    w_next_state = r_state;
    case (r_state)
      LOADING: if (w_fall)       w_next_state = FLUSH;
      FLUSH:   if (w_flush_done) w_next_state = READY;
      default: ;
    endcase
    if (w_start) w_next_state = LOADING;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge register values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dl_d       <= 1'b0;
      r_hold       <= '0;
      r_hold_cnt   <= '0;
      r_rec_cnt    <= '0;
      r_rom_wren   <= 1'b0;
      r_inc_pend   <= 1'b0;
      r_rom_data   <= '0;
      r_write_addr <= '0;
      r_load_error <= '0;
      r_mask_ready <= 1'b0;
    end else begin
      r_dl_d     <= bus.ioctl_download;
      r_rom_wren <= 1'b0;
      r_inc_pend <= r_rom_wren;
      if (r_inc_pend) r_write_addr <= r_write_addr + ADDR_WIDTH'(1);

      if (w_start) begin
        r_hold       <= '0;
        r_hold_cnt   <= '0;
        r_rec_cnt    <= '0;
        r_rom_wren   <= 1'b0;
        r_inc_pend   <= 1'b0;
        r_write_addr <= '0;
        r_load_error <= '0;
        r_mask_ready <= 1'b0;
      end else begin
        if (w_accept) begin
          r_hold     <= bus.ioctl_dout;
          r_hold_cnt <= 2'd2;
        end else if (w_shift) begin
          r_rom_data <= {r_hold[7:0], r_rom_data[39:8]};
          r_hold     <= {8'h00, r_hold[15:8]};
          r_hold_cnt <= r_hold_cnt - 2'd1;
          if (r_rec_cnt == 3'd4) begin
            r_rec_cnt <= '0;
            // A full ROM turns further records into an overflow, not a write.
            if (r_write_addr == MAX_ADDR) r_load_error[0] <= 1'b1;
            else                          r_rom_wren      <= 1'b1;
          end else begin
            r_rec_cnt <= r_rec_cnt + 3'd1;
          end
        end

        if (w_flush_done) begin
          if (r_rec_cnt != 3'd0) begin
            r_load_error[1] <= 1'b1;
            r_rec_cnt       <= '0;
          end
          r_mask_ready <= (r_write_addr != '0) && (r_load_error == 2'b00)
                          && (r_rec_cnt == 3'd0);
        end
      end
    end
  end

  assign bus.ioctl_wait   = w_shift;
  assign bus.rom_wren     = r_rom_wren;
  assign bus.rom_data     = r_rom_data;
  assign bus.rom_addr     = (r_state == LOADING || r_state == FLUSH) ? r_write_addr
                                                                     : bus.render_addr;
  assign bus.record_count = r_write_addr;
  assign bus.load_error   = r_load_error;
  assign bus.mask_ready   = r_mask_ready;
  assign bus.render_hold  = ~r_mask_ready;

endmodule
